// File: rtl/imem_port_arbiter.sv
// Single-port program/data RAM arbiter: CPU fetch, CPU load/store and boot loader
// share one synchronous RAM, one access per cycle, acks one cycle after grant.
module imem_port_arbiter #(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 32,
    parameter bit          DATA_WR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_inst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              ld_mode,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic              err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_D, GNT_LD} gnt_e;

    gnt_e              gnt;
    logic              last_data;
    logic              if_flt, d_flt;
    logic              if_flt_q, d_flt_q, d_rd_q;
    logic [DATA_W-1:0] if_hold, d_hold;
    logic              e_if, e_d, e_ld;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[31:ADDR_W+2] != '0) || (a[1:0] != 2'b00);
    endfunction

    always_comb begin
        // A requester whose ack is pending this cycle still counts as in flight.
        e_if   = if_req & ~if_ack;
        e_d    = d_req  & ~d_ack;
        e_ld   = ld_req & ~ld_ack;
        if_flt = addr_bad(if_addr);
        d_flt  = addr_bad(d_addr) | (d_we & ~DATA_WR_EN);
        gnt    = GNT_NONE;
        if (!clrn) begin
            gnt = GNT_NONE;
        end else if (ld_mode) begin
            if (e_ld) gnt = GNT_LD;
        end else if (e_if && e_d) begin
            gnt = last_data ? GNT_IF : GNT_D;
        end else if (e_if) begin
            gnt = GNT_IF;
        end else if (e_d) begin
            gnt = GNT_D;
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (gnt)
            GNT_IF: begin
                ram_en   = ~if_flt;
                ram_addr = if_addr[ADDR_W+1:2];
            end
            GNT_D: begin
                ram_en    = ~d_flt;
                ram_we    = d_we & ~d_flt;
                ram_addr  = d_addr[ADDR_W+1:2];
                ram_wdata = d_wdata;
            end
            GNT_LD: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = ld_addr;
                ram_wdata = ld_wdata;
            end
            default: ;
        endcase
    end

    // RAM data arrives in the ack cycle, so it is bypassed straight out and
    // latched into the hold register at the end of that cycle.
    always_comb begin
        if_inst = if_ack ? (if_flt_q ? '0 : ram_rdata) : if_hold;
        d_rdata = (d_ack && d_rd_q) ? (d_flt_q ? '0 : ram_rdata) : d_hold;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            ld_ack    <= 1'b0;
            err       <= 1'b0;
            last_data <= 1'b1;
            if_flt_q  <= 1'b0;
            d_flt_q   <= 1'b0;
            d_rd_q    <= 1'b0;
            if_hold   <= '0;
            d_hold    <= '0;
        end else begin
            if_ack <= (gnt == GNT_IF);
            d_ack  <= (gnt == GNT_D);
            ld_ack <= (gnt == GNT_LD);
            err    <= ((gnt == GNT_IF) && if_flt) || ((gnt == GNT_D) && d_flt);
            if (gnt == GNT_IF) begin
                last_data <= 1'b0;
                if_flt_q  <= if_flt;
            end
            if (gnt == GNT_D) begin
                last_data <= 1'b1;
                d_flt_q   <= d_flt;
                d_rd_q    <= ~d_we;
            end
            if (if_ack) if_hold <= if_inst;
            if (d_ack && d_rd_q) d_hold <= d_rdata;
        end
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-port synchronous 64x32 program/data RAM between three requesters: CPU instruction fetch, CPU data load/store, and a boot loader that writes program words.
- Arbitrates one RAM access per cycle and returns read data with a one-cycle-latency ack.
- Replaces the dual combinational read ports of the current instruction memory with a clocked, shareable RAM.
- Sits between the CPU core, the loader, and the RAM macro.

Parameters:
- ADDR_W, 6, word-index width; RAM depth = 2^ADDR_W words.
- DATA_W, 32, word width.
- DATA_WR_EN, 1, 1 = CPU data port may write RAM; 0 = CPU data writes are blocked and flagged as errors.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  32  fetch byte address.
- if_ack  out  1  one-cycle pulse; if_inst valid this cycle.
- if_inst  out  DATA_W  fetched word.
- d_req  in  1  data request; held with d_we, d_addr, d_wdata stable until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle pulse; access complete.
- d_rdata  out  DATA_W  load data.
- ld_mode  in  1  loader owns RAM; CPU ports are not granted.
- ld_req  in  1  loader write request; held until ld_ack.
- ld_addr  in  ADDR_W  loader word index.
- ld_wdata  in  DATA_W  loader word.
- ld_ack  out  1  one-cycle pulse; write done.
- err  out  1  one-cycle pulse together with the ack of a faulted CPU access.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM word index.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid the cycle after ram_en with ram_we=0.

Behaviour:
- Reset (clrn=0, async):
  - all acks, err, ram_en, ram_we = 0; ram_addr, ram_wdata, if_inst, d_rdata = 0.
  - Round-robin pointer = "data last", so fetch wins the first tie.
  - Any in-flight access is discarded and never acked.
- Issue/ack timing:
  - An access granted in cycle t drives ram_* combinationally in cycle t.
  - The matching ack is registered and high in cycle t+1.
  - Read data is captured from ram_rdata into if_inst/d_rdata in cycle t+1.
  - if_inst and d_rdata hold their values until the next read ack on that port; write acks leave d_rdata unchanged.
- Eligibility:
  - A requester is eligible when its req is high and it has no access in flight.
  - The in-flight flag is set at grant and cleared when the ack is issued.
  - So the same requester is not re-granted in its ack cycle, even with req still high.
  - Per-requester throughput: 1 access / 2 cycles. Alternating requesters: 1 access / cycle.
- Priority:
  - ld_mode=1: only the loader is eligible. if_req/d_req wait unacknowledged.
  - ld_mode=0: the loader is ignored. Fetch vs data is round-robin; the pointer updates only when a CPU grant occurs. A single eligible requester always wins.
- ld_mode change with an access in flight: that access still completes and acks normally. The new mode applies to grants from the next cycle.
- Address mapping:
  - CPU word index = addr[ADDR_W+1:2].
  - CPU fault conditions:
    - addr[31:ADDR_W+2] != 0.
    - addr[1:0] != 0.
    - d_we=1 with DATA_WR_EN=0.
  - A fault still consumes the grant slot, but ram_en=0 that cycle.
  - At t+1 the port's ack and err pulse together; read data is forced to 0.
- Loader: ram_we=1, ram_wdata=ld_wdata, ram_addr=ld_addr; never faults.
- No grant: ram_en=0, ram_we=0; ram_addr/ram_wdata may hold their previous values.
- Ack pulses on different ports never coincide, because one grant is made per cycle.

Test Plan:
- Reset release, if_req=1, if_addr=0x0, RAM[0]=0x3C03C000 -> ram_en in cycle 0, if_ack in cycle 1 with if_inst=0x3C03C000; next grant in cycle 2 (no grant in cycle 1).
- if_req and d_req (read, 0x10) both held -> grants alternate fetch, data, fetch, data; acks pulse every cycle; d_rdata=RAM[4].
- ld_mode=1, loader writes 0xDEADBEEF to index 63 while if_req=1 -> fetch not acked; ld_ack the cycle after grant; after ld_mode=0, a fetch of 0xFC returns 0xDEADBEEF.
- d_req write to addr 0x100, then a separate d_req write to 0x06 -> each: ram_en=0, d_ack+err pulse one cycle later, RAM unchanged.
- DATA_WR_EN=0, data write to 0x20 -> d_ack+err, RAM[8] unchanged; a following read of 0x20 acks with no err.
- clrn asserted in the cycle between grant and ack -> no ack, all outputs 0; after release, a fetch retried with if_req=1 completes normally.
